// File: rtl/sel_pkg.sv
// Shared select-code definitions and the pure decode function used by the
// decoder RTL and by encoder-side reference models.
package sel_pkg;

  localparam logic [1:0] SEL_CODE_1  = 2'b00;
  localparam logic [1:0] SEL_CODE_2  = 2'b01;
  localparam logic [1:0] SEL_CODE_3  = 2'b10;
  localparam logic [1:0] SEL_CODE_23 = 2'b11;

  localparam logic [2:0] SEL_OH_1  = 3'b001;
  localparam logic [2:0] SEL_OH_2  = 3'b010;
  localparam logic [2:0] SEL_OH_3  = 3'b100;
  localparam logic [2:0] SEL_OH_23 = 3'b110;

  function automatic logic [2:0] sel_decode(input logic [1:0] code);
    logic [2:0] sel;
    case (code)
      SEL_CODE_1: sel = SEL_OH_1;
      SEL_CODE_2: sel = SEL_OH_2;
      SEL_CODE_3: sel = SEL_OH_3;
      default:    sel = SEL_OH_23;
    endcase
    return sel;
  endfunction

  function automatic logic sel_is_multi(input logic [2:0] sel);
    return (sel[0] & sel[1]) | (sel[0] & sel[2]) | (sel[1] & sel[2]);
  endfunction

endpackage

// File: rtl/sel_fifo.sv
// DEPTH x DATA_W synchronous FIFO; push into a full FIFO is refused even when
// a pop happens on the same edge, so full never depends on the pop input.
module sel_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              do_push, do_pop;

  assign full_o  = (occ_q == OCC_W'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is data only; validity is carried entirely by the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sel_decoder.sv
// Registered select-code decoder: FIFO-buffered codes, decoded head output,
// and per-select saturating usage counters.
module sel_decoder
  import sel_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_sel,
  output logic             out_multi,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_sel1,
  output logic [CNT_W-1:0] cnt_sel2,
  output logic [CNT_W-1:0] cnt_sel3
);

  logic [1:0]       head_code;
  logic             full, empty, push, pop;
  logic [2:0]       head_sel;
  logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d, cnt3_q, cnt3_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  sel_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (in_code),
    .pop_i   (pop),
    .rdata_o (head_code),
    .full_o  (full),
    .empty_o (empty)
  );

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head storage is not reset, so the decode is masked whenever the FIFO is empty.
  assign head_sel  = empty ? 3'b000 : sel_decode(head_code);
  assign out_sel   = head_sel;
  assign out_multi = sel_is_multi(head_sel);

  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    cnt3_d = cnt3_q;
    if (cnt_clr) begin
      cnt1_d = '0;
      cnt2_d = '0;
      cnt3_d = '0;
    end else if (pop) begin
      if (head_sel[0]) cnt1_d = sat_inc(cnt1_q);
      if (head_sel[1]) cnt2_d = sat_inc(cnt2_q);
      if (head_sel[2]) cnt3_d = sat_inc(cnt3_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
      cnt3_q <= '0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
      cnt3_q <= cnt3_d;
    end
  end

  assign cnt_sel1 = cnt1_q;
  assign cnt_sel2 = cnt2_q;
  assign cnt_sel3 = cnt3_q;

endmodule
